// File: rtl/audio_pkg.sv
// Shared audio definitions: sample/frame widths, transmitter state and frame bit selection.
package audio_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned K_W        = $clog2(FRAME_BITS);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } tx_state_t;

    // Bit of W carried in BCLK period k: 31 - ((k-1) mod 32), i.e. one-period MSB delay.
    function automatic logic [K_W-1:0] frame_bit_sel(input logic [K_W-1:0] k);
        return ~(k - K_W'(1));
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; a push while full is taken only alongside a pop.
module sample_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo I2S transmitter with priming FIFO and underrun/overflow reporting.
// Define I2S_TX_STATS_EN to build the saturating underrun/overflow counters.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_W-1:0]           sample_in,
    input  logic                          sample_in_valid,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun_pulse,
    output logic                          overflow_pulse,
    output logic [15:0]                   underrun_count,
    output logic [15:0]                   overflow_count
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0] PRIME_LEVEL = LVL_W'(FIFO_DEPTH / 2);

    logic [DIV_W-1:0]      div_cnt;
    logic                  bclk_q;
    logic                  lrclk_q;
    logic                  sdata_q;
    logic [K_W-1:0]        bit_k;
    logic [FRAME_BITS-1:0] frame_w;
    tx_state_t             state;
    logic                  underrun_q;
    logic                  overflow_q;

    logic                  div_wrap;
    logic                  fall_edge;
    logic                  frame_start;
    logic                  pop_req;
    logic                  underrun_evt;
    logic                  overflow_evt;
    logic [K_W-1:0]        next_k;
    logic [FRAME_BITS-1:0] next_w;

    logic [SAMPLE_W-1:0]   fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_lvl;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sample_in_valid),
        .push_data (sample_in),
        .pop       (pop_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_lvl)
    );

    // Period 1 begins on the BCLK falling edge that leaves period 0.
    assign div_wrap     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign fall_edge    = div_wrap & bclk_q;
    assign frame_start  = fall_edge & (bit_k == '0);
    assign pop_req      = frame_start & (state == RUN) & ~fifo_empty;
    assign underrun_evt = frame_start & (state == RUN) & fifo_empty;
    assign overflow_evt = sample_in_valid & fifo_full & ~pop_req;

    always_comb begin
        next_k = bit_k + 1'b1;
        next_w = frame_w;
        if (frame_start) begin
            next_w = pop_req ? {fifo_head, fifo_head} : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            bit_k      <= '0;
            frame_w    <= '0;
            state      <= PRIME;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            underrun_q <= underrun_evt;
            overflow_q <= overflow_evt;

            if (div_wrap) begin
                div_cnt <= '0;
                bclk_q  <= ~bclk_q;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            // Word select and data both advance only as BCLK falls.
            if (fall_edge) begin
                bit_k   <= next_k;
                lrclk_q <= next_k[K_W-1];
                sdata_q <= next_w[frame_bit_sel(next_k)];
            end

            if (frame_start) begin
                frame_w <= next_w;
                case (state)
                    PRIME: begin
                        if (fifo_lvl >= PRIME_LEVEL) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (fifo_empty) begin
                            state <= PRIME;
                        end
                    end
                    default: state <= PRIME;
                endcase
            end
        end
    end

    assign i2s_bclk       = bclk_q;
    assign i2s_lrclk      = lrclk_q;
    assign i2s_sdata      = sdata_q;
    assign fifo_level     = fifo_lvl;
    assign underrun_pulse = underrun_q;
    assign overflow_pulse = overflow_q;

`ifdef I2S_TX_STATS_EN
    logic [15:0] underrun_cnt;
    logic [15:0] overflow_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            if (underrun_evt && (underrun_cnt != '1)) begin
                underrun_cnt <= underrun_cnt + 1'b1;
            end
            if (overflow_evt && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

    assign underrun_count = underrun_cnt;
    assign overflow_count = overflow_cnt;
`else
    assign underrun_count = '0;
    assign overflow_count = '0;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: queue-based frame model plus a serial I2S receiver that decodes the line.
module tb_i2s_tx;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned HALF_CLKS  = 4;    // clk cycles per BCLK period
    localparam int unsigned FRAME_CLKS = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample_in = '0;
    logic        sample_in_valid = 1'b0;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic [4:0]  fifo_level;
    logic        underrun_pulse;
    logic        overflow_pulse;
    logic [15:0] underrun_count;
    logic [15:0] overflow_count;

    always #5 clk = ~clk;

    i2s_tx #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_in       (sample_in),
        .sample_in_valid (sample_in_valid),
        .i2s_bclk        (i2s_bclk),
        .i2s_lrclk       (i2s_lrclk),
        .i2s_sdata       (i2s_sdata),
        .fifo_level      (fifo_level),
        .underrun_pulse  (underrun_pulse),
        .overflow_pulse  (overflow_pulse),
        .underrun_count  (underrun_count),
        .overflow_count  (overflow_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: clk edges since reset release, sample queue, expected frame words.
    int unsigned n;
    logic        run;
    logic [15:0] mq[$];
    logic [15:0] frames[$];
    logic        exp_ur;
    logic        exp_of;
    int unsigned ucnt;
    int unsigned ocnt;

    // Receiver state.
    logic        prev_bclk;
    logic        prev_lr;
    logic [31:0] sr;
    int unsigned rise_idx;

    task automatic model_edge(input logic r, input logic v, input logic [15:0] d);
        logic boundary;
        exp_ur = 1'b0;
        exp_of = 1'b0;
        if (r) begin
            n = 0; run = 1'b0; ucnt = 0; ocnt = 0;
            mq.delete(); frames.delete();
            prev_bclk = 1'b0; prev_lr = 1'b0; sr = '0; rise_idx = 0;
            return;
        end
        n++;
        boundary = (n >= HALF_CLKS) && (((n - HALF_CLKS) % FRAME_CLKS) == 0);
        if (boundary) begin
            if (!run) begin
                frames.push_back(16'h0000);
                if (mq.size() >= FIFO_DEPTH / 2) run = 1'b1;
            end else if (mq.size() == 0) begin
                frames.push_back(16'h0000);
                exp_ur = 1'b1;
                run = 1'b0;
                if (ucnt < 16'hFFFF) ucnt++;
            end else begin
                frames.push_back(mq.pop_front());
            end
        end
        if (v) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back(d);
            else begin
                exp_of = 1'b1;
                if (ocnt < 16'hFFFF) ocnt++;
            end
        end
    endtask

    task automatic check_outputs(input logic r);
        logic [15:0] f;
        check("bclk", i2s_bclk, (n / CLK_DIV) % 2);
        check("fifo_level", fifo_level, mq.size());
        check("underrun_pulse", underrun_pulse, exp_ur);
        check("overflow_pulse", overflow_pulse, exp_of);
`ifdef I2S_TX_STATS_EN
        check("underrun_count", underrun_count, ucnt);
        check("overflow_count", overflow_count, ocnt);
`else
        check("underrun_count_tied", underrun_count, 0);
        check("overflow_count_tied", overflow_count, 0);
`endif
        if (r) begin
            check("rst_lrclk", i2s_lrclk, 0);
            check("rst_sdata", i2s_sdata, 0);
        end
        if (!prev_bclk && i2s_bclk) begin
            check("lrclk", i2s_lrclk, (rise_idx % 32) >= 16);
            sr = {sr[30:0], i2s_sdata};
            if (prev_lr && !i2s_lrclk) begin
                check("frame_avail", frames.size() != 0, 1);
                if (frames.size() != 0) begin
                    f = frames.pop_front();
                    check("frame_word", sr, {f, f});
                end
            end
            prev_lr = i2s_lrclk;
            rise_idx++;
        end
        prev_bclk = i2s_bclk;
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] d);
        rst = r;
        sample_in_valid = v;
        sample_in = d;
        @(posedge clk);
        model_edge(r, v, d);
        @(negedge clk);
        check_outputs(r);
    endtask

    task automatic idle(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) step(1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        @(negedge clk);
        repeat (4) step(1'b1, 1'b0, 16'h0000);

        // Prime with 8 x 0x8001, then let it play out into an underrun.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h8001);
        idle(12 * FRAME_CLKS);

        // Overflow burst straight after reset, before any pop.
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'($urandom));
        check("burst_level", fifo_level, FIFO_DEPTH);
        idle(19 * FRAME_CLKS);

        // Re-prime, then push exactly on the period-1 cycle that finds the FIFO empty in RUN.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'($urandom));
        for (int i = 0; i < 4000; i++) begin
            if (run && (mq.size() == 0) && (((n + 1 - HALF_CLKS) % FRAME_CLKS) == 0)) break;
            step(1'b0, 1'b0, 16'h0000);
        end
        check("reach_empty_boundary", run && (mq.size() == 0), 1);
        step(1'b0, 1'b1, 16'h1234);
        check("push_on_empty_underrun", underrun_pulse, 1);
        check("push_on_empty_level", fifo_level, 1);
        idle(2 * FRAME_CLKS);

        // Random traffic: dense phase drives overflow, sparse phase drives underruns.
        for (int i = 0; i < 3000; i++) step(1'b0, ($urandom % 8) == 0, 16'($urandom));
        for (int i = 0; i < 3000; i++) step(1'b0, ($urandom % 150) == 0, 16'($urandom));
        for (int i = 0; i < 600; i++) step(1'b0, ($urandom % 3) == 0, 16'($urandom));

        // Reset in the middle of period 20.
        for (int i = 0; i < 400; i++) begin
            if (((n / HALF_CLKS) % 32) == 20) break;
            step(1'b0, 1'b0, 16'h0000);
        end
        check("reach_period20", (n / HALF_CLKS) % 32, 20);
        step(1'b1, 1'b0, 16'h0000);
        check("rst20_bclk", i2s_bclk, 0);
        check("rst20_lrclk", i2s_lrclk, 0);
        check("rst20_sdata", i2s_sdata, 0);
        check("rst20_level", fifo_level, 0);
        check("rst20_pulses", {underrun_pulse, overflow_pulse}, 0);
        step(1'b0, 1'b0, 16'h0000);
        check("post_rst_bclk_n1", i2s_bclk, 0);
        step(1'b0, 1'b0, 16'h0000);
        check("post_rst_bclk_n2", i2s_bclk, 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'($urandom));
        idle(4 * FRAME_CLKS);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
